// File: rtl/mips_pkg.sv
// mips_pkg: ALU control codes, alu_op encodings and R-type funct values shared by the ID/EX stage.
package mips_pkg;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_BAD = 4'b1111;
   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;
   localparam logic [1:0] OP_OR    = 2'b11;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_NOR = 6'b100111;
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational alu_op/funct to 4-bit ALU code, flagging unsupported R-type funct.
module alu_ctrl_dec
   import mips_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] code,
   output logic       illegal
);
   logic [3:0] rcode;
   assign rcode = funct == F_ADD ? ALU_ADD :
                  funct == F_SUB ? ALU_SUB :
                  funct == F_AND ? ALU_AND :
                  funct == F_OR  ? ALU_OR  :
                  funct == F_SLT ? ALU_SLT :
                  funct == F_NOR ? ALU_NOR : ALU_BAD;
   assign code = alu_op == OP_ADD ? ALU_ADD :
                 alu_op == OP_SUB ? ALU_SUB :
                 alu_op == OP_OR  ? ALU_OR  : rcode;
   assign illegal = alu_op == OP_RTYPE && rcode == ALU_BAD;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode and operand issue.
// Define FORWARDING_EN to enable the EX/MEM and MEM/WB forwarding mux on rs/rt.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [1:0]        id_alu_op,
   input  logic [5:0]        id_funct,
   input  logic              id_alu_src,
   input  logic              id_reg_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              fwd_mem_we,
   input  logic              fwd_wb_we,
   input  logic [REG_AW-1:0] fwd_mem_rd,
   input  logic [REG_AW-1:0] fwd_wb_rd,
   input  logic [DATA_W-1:0] fwd_mem_data,
   input  logic [DATA_W-1:0] fwd_wb_data,
   output logic              ex_valid,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [3:0]        alu_ctrl,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_dst,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              ex_illegal
);
   localparam int SW = 3 * DATA_W + 3 * REG_AW + 11;
   logic [3:0]        code;
   logic              illegal;
   logic              bubble;
   logic [SW-1:0]     st_d, st_q;
   logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q, rs_fwd, rt_fwd;
   logic [REG_AW-1:0] rs_q, rt_q;
   logic              alu_src_q;
   alu_ctrl_dec u_dec (.alu_op(id_alu_op), .funct(id_funct), .code(code), .illegal(illegal));
   assign bubble = flush || !id_valid;
   assign st_d = bubble ? '0 : {1'b1, id_rs_data, id_rt_data, id_imm, id_rs, id_rt,
                                id_reg_dst ? id_rd : id_rt, id_alu_src, code, illegal,
                                id_reg_write && !illegal, id_mem_read, id_mem_write, id_mem_to_reg};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st_q <= '0;
      else if (flush || !stall) st_q <= st_d;
   assign {ex_valid, rs_data_q, rt_data_q, imm_q, rs_q, rt_q, ex_dst, alu_src_q, alu_ctrl, ex_illegal,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} = st_q;
`ifdef FORWARDING_EN
   assign rs_fwd = fwd_mem_we && fwd_mem_rd != '0 && fwd_mem_rd == rs_q ? fwd_mem_data :
                   fwd_wb_we  && fwd_wb_rd  != '0 && fwd_wb_rd  == rs_q ? fwd_wb_data  : rs_data_q;
   assign rt_fwd = fwd_mem_we && fwd_mem_rd != '0 && fwd_mem_rd == rt_q ? fwd_mem_data :
                   fwd_wb_we  && fwd_wb_rd  != '0 && fwd_wb_rd  == rt_q ? fwd_wb_data  : rt_data_q;
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_mem_we, fwd_wb_we, fwd_mem_rd, fwd_wb_rd, fwd_mem_data, fwd_wb_data, rs_q, rt_q};
   assign rs_fwd = rs_data_q;
   assign rt_fwd = rt_data_q;
`endif
   assign alu_in1 = rs_fwd;
   assign alu_in2 = alu_src_q ? imm_q : rt_fwd;
   assign ex_store_data = rt_fwd;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-issue stage directly upstream of the 32-bit ALU.
- Captures decoded operands and control from ID and generates the ALU's 4-bit control code from alu_op/funct.
- Drives alu_in1/alu_in2/alu_ctrl into the ALU and passes memory/writeback control onward to EX/MEM.
- Honours stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all stage registers.
- flush  in  1  load a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_rs, id_rt, id_rd  in  REG_AW  register indices.
- id_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or.
- id_funct  in  6  R-type funct field.
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  decoded control.
- fwd_mem_we, fwd_wb_we  in  1  EX/MEM and MEM/WB write enables.
- fwd_mem_rd, fwd_wb_rd  in  REG_AW  destination indices.
- fwd_mem_data, fwd_wb_data  in  DATA_W  results being written.
- ex_valid  out  1  EX holds a real instruction.
- alu_in1, alu_in2  out  DATA_W  ALU operands.
- alu_ctrl  out  4  ALU control code.
- ex_store_data  out  DATA_W  rt value (post-forward) for stores.
- ex_dst  out  REG_AW  writeback register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  control passed to EX/MEM.
- ex_illegal  out  1  R-type funct not supported.

Behaviour:
- Reset (async, rst_n=0): all stage registers cleared; ex_valid=0, all control outputs 0, alu_ctrl=4'b0000, ex_dst=0, data outputs 0. Release takes effect on the next edge.
- Per edge, priority flush > stall > load:
  - flush: load a bubble (all registers 0, ex_valid=0).
  - stall (no flush): all registers hold.
  - otherwise: capture ID inputs.
- Latency: one cycle from ID input to EX output. Forwarding is combinational on the registered indices.
- id_valid=0 on load: captured as a bubble, identical to flush.
- ALU control decode happens at capture; the code is registered:
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0001.
  - alu_op 10, by funct: 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111; 100111 -> 1100.
  - Any other funct: alu_ctrl=1111, ex_illegal=1, reg_write forced 0.
- ex_dst = id_reg_dst ? id_rd : id_rt, selected at capture.
- Operand A = forwarded rs. Operand B = alu_src ? imm : forwarded rt. ex_store_data = forwarded rt.
- Forward select for rs (rt identical):
  - fwd_mem_we and fwd_mem_rd!=0 and fwd_mem_rd==rs_q -> fwd_mem_data;
  - else fwd_wb_we and fwd_wb_rd!=0 and fwd_wb_rd==rs_q -> fwd_wb_data;
  - else the registered value.
  - Both sources matching: EX/MEM wins. Register 0 is never forwarded.
- During a bubble, outputs still evaluate the forward mux, but ex_valid and all write/mem controls are 0.
- Stall while EX/MEM data changes: operands re-evaluate combinationally each cycle; no stale capture.

Optional Feature:
- FORWARDING_EN.
- Defined: forwarding mux as above.
- Undefined: alu_in1/alu_in2/ex_store_data come straight from the registered values. fwd_* inputs are ignored, and the hazard unit must stall instead.

Decomposition:
- Shared package mips_pkg holds:
  - ALU code constants: ALU_AND 4'b0000, ALU_OR 4'b0001, ALU_ADD 4'b0010, ALU_SUB 4'b0110, ALU_SLT 4'b0111, ALU_NOR 4'b1100, ALU_BAD 4'b1111.
  - alu_op encodings.
  - funct constants.
- One sub-module, alu_ctrl_dec: combinational alu_op/funct -> code plus illegal flag, instantiated before the capture register.

Test Plan:
- Reset mid-operation: load valid add, assert rst_n=0 between edges -> all outputs 0 immediately, ex_valid=0.
- R-type decode: alu_op=10, funct=101010, rs_data=5, rt_data=9 -> next cycle alu_ctrl=0111, alu_in1=5, alu_in2=9. funct=000001 -> alu_ctrl=1111, ex_illegal=1, ex_reg_write=0.
- Immediate path: alu_op=00, alu_src=1, imm=0xFFFFFFFC, reg_dst=0, rt=7 -> alu_ctrl=0010, alu_in2=0xFFFFFFFC, ex_dst=7.
- Forwarding (FORWARDING_EN): rs_q=3; fwd_mem (we=1, rd=3, data=0xAA) and fwd_wb (we=1, rd=3, data=0xBB) -> alu_in1=0xAA. Drop fwd_mem_we -> 0xBB. rd=0 on both -> registered value.
- Stall/flush: stall=1 for 3 cycles with changing ID inputs -> outputs unchanged. stall=1 and flush=1 together -> bubble (ex_valid=0, ex_reg_write=0, alu_ctrl=0000).
- Non-forwarding build: same stimulus as the forwarding test -> alu_in1 equals the captured id_rs_data.
